// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction field positions, the NOP encoding,
// and the packed pipeline-entry type used by the fetch/decode buffer.
package mips_pkg;

    localparam int INSTR_W   = 32;
    localparam int PC_W_MAX  = 32;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_LSB = 6;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

    // One buffered fetch result; pc4 is sized for the widest supported PC.
    typedef struct packed {
        logic                valid;
        logic [INSTR_W-1:0]  instr;
        logic [PC_W_MAX-1:0] pc4;
    } ifid_entry_t;

endpackage

// File: rtl/if_id_skid_buf.sv
// Two-entry valid/ready buffer between fetch and decode. The head entry
// drives the outputs; the skid entry catches the word that arrives while
// decode is stalling, so ready can be a registered signal.
module if_id_skid_buf
    import mips_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               InValid,
    output logic               InReady,
    input  logic [INSTR_W-1:0] Instr,
    input  logic [PC_W-1:0]    PCPlus4,
    input  logic               Flush,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [INSTR_W-1:0] HeadInstr,
    output logic [PC_W-1:0]    HeadPCPlus4
);

    ifid_entry_t headReg;
    ifid_entry_t skidReg;
    ifid_entry_t inEntry;
    logic        accept;
    logic        pop;

    assign InReady  = ~skidReg.valid;
    assign OutValid = headReg.valid;
    assign accept   = InValid & InReady & ~Flush;
    assign pop      = headReg.valid & OutReady;

    assign inEntry.valid = 1'b1;
    assign inEntry.instr = Instr;
    assign inEntry.pc4   = PC_W_MAX'(PCPlus4);

    assign HeadInstr   = headReg.instr;
    assign HeadPCPlus4 = headReg.pc4[PC_W-1:0];

    // Head/skid update: flush beats everything, and the skid entry always
    // drains into head before any new word, which keeps program order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            headReg <= '{valid: 1'b0, instr: NOP_INSTR, pc4: '0};
            skidReg <= '{valid: 1'b0, instr: NOP_INSTR, pc4: '0};
        end else if (Flush) begin
            headReg.valid <= 1'b0;
            headReg.instr <= NOP_INSTR;
            skidReg.valid <= 1'b0;
        end else if (!headReg.valid || (pop && !skidReg.valid)) begin
            if (accept) begin
                headReg <= inEntry;
            end else begin
                headReg.valid <= 1'b0;
            end
        end else if (pop) begin
            // Skid is full here, so InReady is low and nothing is accepted.
            headReg       <= skidReg;
            skidReg.valid <= 1'b0;
        end else if (accept) begin
            skidReg <= inEntry;
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: buffers fetched instructions with their PC+4 and
// slices the head instruction into decode fields.
// Optional stall counter enabled by defining IF_ID_PERF_EN.
module if_id_stage
    import mips_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               InValid,
    output logic               InReady,
    input  logic [INSTR_W-1:0] Instr,
    input  logic [PC_W-1:0]    PCPlus4,
    input  logic               Flush,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [5:0]         Opcode,
    output logic [4:0]         Rs,
    output logic [4:0]         Rt,
    output logic [4:0]         Rd,
    output logic [4:0]         Shamt,
    output logic [5:0]         Funct,
    output logic [15:0]        Imm16,
    output logic [25:0]        JTarget,
`ifdef IF_ID_PERF_EN
    input  logic               CntClr,
    output logic [15:0]        StallCount,
`endif
    output logic [PC_W-1:0]    PCPlus4Out
);

    logic [INSTR_W-1:0] headInstr;

    if_id_skid_buf #(
        .PC_W(PC_W)
    ) skidBuf (
        .Clk        (Clk),
        .Reset      (Reset),
        .InValid    (InValid),
        .InReady    (InReady),
        .Instr      (Instr),
        .PCPlus4    (PCPlus4),
        .Flush      (Flush),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .HeadInstr  (headInstr),
        .HeadPCPlus4(PCPlus4Out)
    );

    assign Opcode  = headInstr[OP_MSB:OP_LSB];
    assign Rs      = headInstr[RS_LSB+4:RS_LSB];
    assign Rt      = headInstr[RT_LSB+4:RT_LSB];
    assign Rd      = headInstr[RD_LSB+4:RD_LSB];
    assign Shamt   = headInstr[SHAMT_LSB+4:SHAMT_LSB];
    assign Funct   = headInstr[SHAMT_LSB-1:0];
    assign Imm16   = headInstr[15:0];
    assign JTarget = headInstr[RS_LSB+4:0];

`ifdef IF_ID_PERF_EN
    logic [15:0] stallCountReg;

    assign StallCount = stallCountReg;

    // Saturating count of cycles where decode holds off a valid head entry.
    always_ff @(posedge Clk) begin
        if (Reset || CntClr) begin
            stallCountReg <= '0;
        end else if (OutValid && !OutReady && stallCountReg != 16'hFFFF) begin
            stallCountReg <= stallCountReg + 16'd1;
        end
    end
`endif

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Fetch-to-decode pipeline stage of the MIPS CPU. Captures each fetched 32-bit instruction with its PC+4 and splits it into decode fields.
- The Imm16 output feeds the 16-to-32 sign extender; the other fields go to the register file and control unit.
- Valid/ready handshake on both sides, plus a 2-entry skid buffer, so a decode stall never drops a fetched word.
- Flush input squashes wrong-path instructions after a branch or jump.

Parameters:
- PC_W, 32, width of PC+4 carried alongside the instruction.
- INSTR_W, 32, instruction width; fixed at 32, and field slicing depends on it.

Ports:
- Clk  input  1  rising-edge clock; the only clock.
- Reset  input  1  synchronous, active-high reset.
- InValid  input  1  fetch presents a valid instruction.
- InReady  output  1  stage can accept an instruction this cycle.
- Instr  input  32  fetched instruction word.
- PCPlus4  input  PC_W  PC+4 of Instr.
- Flush  input  1  squash all held and incoming instructions.
- OutValid  output  1  decode fields valid.
- OutReady  input  1  decode consumes the current entry.
- Opcode  output  6  Instr[31:26] of the head entry.
- Rs  output  5  [25:21].
- Rt  output  5  [20:16].
- Rd  output  5  [15:11].
- Shamt  output  5  [10:6].
- Funct  output  6  [5:0].
- Imm16  output  16  [15:0], input to the sign extender.
- JTarget  output  26  [25:0].
- PCPlus4Out  output  PC_W  PC+4 of the head entry.

Behaviour:
- **Reset/clock:** one clock, Clk. Reset is synchronous and active-high.
- **Storage:** head register (drives all outputs) and skid register, each {valid, instr, pc4}.
- **Reset values:** both valid bits 0; head instr 32'h0 (NOP), so every field output is 0; PCPlus4Out 0; OutValid 0; InReady 1 from the first cycle after reset.
- **Handshake:**
  - accept = InValid & InReady & ~Flush.
  - pop = OutValid & OutReady.
  - OutValid = head.valid.
  - InReady = ~skid.valid. It is registered state, not combinational from OutReady.
- **Latency:** an accepted instruction appears on the outputs the next cycle when head is empty or popping. Sustained throughput is 1 per cycle.
- **Update cases (priority order):**
  1. Flush: both valids cleared, head instr forced to 0, incoming word discarded. OutValid=0 next cycle. Flush overrides pop and accept.
  2. Head empty, or pop with skid empty: an accepted word loads head directly. With no accept, head.valid follows the pop.
  3. Pop with skid full: skid moves to head and skid.valid clears. InReady is 0 in this case, so no accept is possible.
  4. Head full, no pop, accept: word goes into skid, and InReady goes 0 next cycle.
- **Ordering:** program order is always preserved; skid is never bypassed.
- **Holding:** with no accept and no pop, both registers hold and outputs stay stable.
- **Mid-operation reset:** the same as power-on reset, regardless of occupancy.
- **Inactive inputs:** Instr and PCPlus4 are ignored when InValid=0 or InReady=0.
- **Field outputs:** pure slices of head instr; no decode logic.
- **Datapath:** no arithmetic except the optional counter below.

Optional Feature:
- Macro: IF_ID_PERF_EN.
- **Defined:**
  - Adds output StallCount (16 bits) and input CntClr (1 bit).
  - StallCount increments once per cycle where OutValid=1 and OutReady=0.
  - It saturates at 16'hFFFF.
  - It clears to 0 on Reset or on CntClr; CntClr wins over the increment.
- **Undefined:** neither port exists and there is no counter logic. Behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg:
  - field bit-position constants (OP_MSB=31, RS_LSB=21, RT_LSB=16, RD_LSB=11, SHAMT_LSB=6).
  - NOP_INSTR=32'h0.
  - a packed typedef for the {valid, instr, pc4} entry.
- One natural sub-module: if_id_skid_buf, the 2-entry handshake buffer. The top level only slices fields.

Test Plan:
- **Reset:** drive junk for 3 cycles with Reset=1, then deassert → OutValid=0, InReady=1, all fields 0.
- **Pass-through:** Instr=32'h2008FFFF, PCPlus4=32'h00400004, OutReady=1 → next cycle OutValid=1, Opcode=6'h08, Rs=0, Rt=8, Imm16=16'hFFFF, PCPlus4Out=32'h00400004.
- **Backpressure:** OutReady=0 and push A, B, C on consecutive cycles → A at head, B in skid, InReady=0 from the cycle after B, C not accepted. Then raise OutReady → A, B, C pop on consecutive cycles in order.
- **Flush:** with both entries full, assert Flush together with InValid=1 (Instr=32'h08100000) → next cycle OutValid=0, InReady=1, Opcode=0; the flushed word never appears.
- **Streaming:** push 8 instructions back-to-back with OutReady=1 → 8 consecutive OutValid cycles with matching PCPlus4Out; skid never occupied.
- **Perf counter (IF_ID_PERF_EN):** hold a valid entry with OutReady=0 for 5 cycles → StallCount=5. Then pulse CntClr → StallCount=0.
